cavlc_level_encoder: RTL and testbench
======================================

Name: cavlc_level_encoder

Overview:
- Encoder-side counterpart of the CAVLC level decode path.
- Takes signed coefficient levels of one 4x4 block, highest-frequency first, and produces H.264 level_prefix/level_suffix codewords, or trailing-one sign bits.
- Tracks suffixLength adaptively across the block.
- Feeds the CAVLC bitstream packer through a valid/ready handshake.

Parameters:
- LEVEL_W, 13, signed input level width.
- CW_W, 28, codeword width; max codeword is 16 prefix bits + 12 suffix bits.

Ports:
- Clk  in  1  clock.
- nReset  in  1  reset, asynchronous, active-low.
- InValid  in  1  level present.
- InReady  out  1  encoder accepts level this cycle.
- Level  in  LEVEL_W  signed level, two's complement, never 0.
- TrailingOneMode  in  1  level is a trailing one (±1).
- BlkStart  in  1  first level of a block; qualifies TotalCoeff and TrailingOnes.
- TotalCoeff  in  5  nonzero coefficients in block, 1..16.
- TrailingOnes  in  2  trailing ones in block, 0..3.
- OutValid  out  1  codeword present.
- OutReady  in  1  packer accepts codeword.
- CodeWord  out  CW_W  codeword, right-aligned, MSB first on the wire.
- CodeLen  out  5  valid bits in CodeWord, 1..28.
- Err  out  1  escape suffix overflow on this codeword; feature-dependent.

Behaviour:
- Reset: InReady=1 after reset; OutValid=0, CodeWord=0, CodeLen=0, Err=0; internal SuffixLen=0, FirstNonT1=0, both pipeline stages empty.
- Asserting nReset mid-block discards all in-flight levels and block state.
- Two-stage pipeline, latency 2 cycles from accept (InValid&InReady) to OutValid.
  - A stage advances when the next stage is empty or advancing.
  - InReady = !S1valid || S1 advancing.
  - Output holds stable while OutValid & !OutReady.
  - Order is preserved and no level is dropped.
- Stage 1 (level code):
  - LevelCode = Level>0 ? 2*Level-2 : -2*Level-1, computed at 15 bits.
  - Also registers |Level| and the control flags.
- Stage 2 (encode and state), in this order:
  1. BlkStart: SuffixLen = (TotalCoeff>10 && TrailingOnes<3) ? 1 : 0; FirstNonT1 = 1.
  2. TrailingOneMode: CodeWord = Level<0 ? 1 : 0, CodeLen=1. SuffixLen and FirstNonT1 unchanged.
  3. Otherwise, if FirstNonT1 && TrailingOnes<3: LevelCode -= 2. FirstNonT1 cleared.
  4. Encode with SuffixLen==0:
     - LevelCode<14: prefix=LevelCode, no suffix.
     - LevelCode<30: prefix=14, suffix=LevelCode-14, 4 bits.
     - else: prefix=15, suffix=LevelCode-30, 12 bits.
  5. Encode with SuffixLen>0:
     - LevelCode < (15<<SuffixLen): prefix=LevelCode>>SuffixLen, suffix=LevelCode low SuffixLen bits, SuffixLen bits wide.
     - else: prefix=15, suffix=LevelCode-(15<<SuffixLen), 12 bits.
  6. Output: CodeWord = (1<<sufsize)|suffix, i.e. prefix zeros are implicit leading zeros; CodeLen = prefix+1+sufsize.
  7. SuffixLen update after a non-T1 level:
     - if 0, set to 1;
     - then if |Level| > (3<<(SuffixLen-1)) and SuffixLen<6, increment.
     - Both checks apply in the same cycle; saturates at 6.
- BlkStart may arrive while the previous block is still in stage 2. State switches exactly at the BlkStart item; earlier items use the old state.
- A block with only trailing ones never clears FirstNonT1; the next BlkStart reinitialises it.

Optional Feature:
- Macro CAVLC_LVL_ESC_CHK_EN.
- Defined: an escape suffix ≥4096 sets Err=1 with that codeword; the suffix field is saturated to 0xFFF; encoding continues.
- Undefined: Err tied 0; suffix truncated to its low 12 bits; no check logic.

Test Plan:
- BlkStart TotalCoeff=3, TrailingOnes=1 → output sequence:
  - T1 level +1 → CodeWord=0, CodeLen=1.
  - Level 2 (SuffixLen 0, adjusted code 0) → CodeWord=1, CodeLen=1; SuffixLen becomes 1.
  - Level 3 → CodeWord=0x2, CodeLen=4; SuffixLen stays 1.
- BlkStart TotalCoeff=5, TrailingOnes=3, Level=-8 → LevelCode=15 → CodeWord=0x11, CodeLen=19; SuffixLen 0→1→2.
- BlkStart TotalCoeff=4, TrailingOnes=3, Level=20 → CodeWord=0x1008, CodeLen=28, Err=0.
- BlkStart TotalCoeff=11, TrailingOnes=1, T1 then Level=3 → SuffixLen init 1, LevelCode 4-2=2 → CodeWord=0x2, CodeLen=3.
- Backpressure: OutReady=0 for 4 cycles while offering 3 levels → InReady drops after 2 accepted. The third level is accepted once OutReady=1. Outputs stay in order, unchanged while stalled.
- With CAVLC_LVL_ESC_CHK_EN: TrailingOnes=3, Level=2100 (suffix 4168) → Err=1, CodeWord=0x1FFF, CodeLen=28. Without the macro → Err=0, CodeWord=0x1048.

Source files
------------

// File: rtl/cavlc_level_encoder.sv
// CAVLC level encoder: signed 4x4-block levels to level_prefix/level_suffix codewords.
// Optional escape-overflow detection is built when CAVLC_LVL_ESC_CHK_EN is defined.
module cavlc_level_encoder #(
  parameter int LEVEL_W = 13,
  parameter int CW_W    = 28
) (
  input  logic                      Clk,
  input  logic                      nReset,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic signed [LEVEL_W-1:0] Level,
  input  logic                      TrailingOneMode,
  input  logic                      BlkStart,
  input  logic [4:0]                TotalCoeff,
  input  logic [1:0]                TrailingOnes,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic [CW_W-1:0]           CodeWord,
  output logic [4:0]                CodeLen,
  output logic                      Err
);

  localparam int LC_W = 15;
`ifdef CAVLC_LVL_ESC_CHK_EN
  localparam int ESC_W = LC_W;
`else
  localparam int ESC_W = 12;
`endif

  function automatic logic [LC_W-1:0] level_code(input logic signed [LEVEL_W-1:0] lvl);
    logic signed [LC_W-1:0] x;
    logic signed [LC_W-1:0] y;
    x = LC_W'(lvl);
    y = x <<< 1;
    return lvl[LEVEL_W-1] ? $unsigned(-y - 15'sd1) : $unsigned(y - 15'sd2);
  endfunction

  function automatic logic [LEVEL_W-1:0] abs_level(input logic signed [LEVEL_W-1:0] lvl);
    return lvl[LEVEL_W-1] ? $unsigned(-lvl) : $unsigned(lvl);
  endfunction

`ifdef CAVLC_LVL_ESC_CHK_EN
  function automatic logic [11:0] sat12(input logic [ESC_W-1:0] v);
    return (v > ESC_W'(4095)) ? 12'hFFF : v[11:0];
  endfunction
`endif

  logic                 vld_p1;
  logic [LC_W-1:0]      lc_p1;
  logic [LEVEL_W-1:0]   abs_p1;
  logic                 neg_p1;
  logic                 t1m_p1;
  logic                 bs_p1;
  logic [4:0]           tc_p1;
  logic [1:0]           t1s_p1;

  logic [2:0]           suffix_len;
  logic                 first_non_t1;
  logic [1:0]           t1s_blk;

  logic                 s2_adv;
  logic                 acc;

  assign s2_adv  = !OutValid || OutReady;
  assign InReady = !vld_p1 || s2_adv;
  assign acc     = InValid && InReady;

  // Stage 1: level code and control capture
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      vld_p1 <= 1'b0;
    end else if (InReady) begin
      vld_p1 <= InValid;
    end
  end

  always_ff @(posedge Clk) begin
    if (acc) begin
      lc_p1  <= level_code(Level);
      abs_p1 <= abs_level(Level);
      neg_p1 <= Level[LEVEL_W-1];
      t1m_p1 <= TrailingOneMode;
      bs_p1  <= BlkStart;
      tc_p1  <= TotalCoeff;
      t1s_p1 <= TrailingOnes;
    end
  end

  logic [2:0]       sl_cur, sl_nxt;
  logic             first_cur, first_nxt;
  logic [1:0]       t1s_cur;
  logic [LC_W-1:0]  lc;
  logic [LC_W-1:0]  thr;
  logic [ESC_W-1:0] esc;
  logic             is_esc;
  logic [4:0]       prefix;
  logic [3:0]       sufsize;
  logic [11:0]      suffix;
  logic [CW_W-1:0]  cw_n;
  logic [4:0]       len_n;
  logic             err_n;

  always_comb begin
    sl_cur    = suffix_len;
    first_cur = first_non_t1;
    t1s_cur   = t1s_blk;
    if (bs_p1) begin
      sl_cur    = (tc_p1 > 5'd10 && t1s_p1 != 2'd3) ? 3'd1 : 3'd0;
      first_cur = 1'b1;
      t1s_cur   = t1s_p1;
    end
    lc        = lc_p1;
    thr       = '0;
    esc       = '0;
    is_esc    = 1'b0;
    prefix    = '0;
    sufsize   = '0;
    suffix    = '0;
    cw_n      = '0;
    len_n     = '0;
    err_n     = 1'b0;
    sl_nxt    = sl_cur;
    first_nxt = first_cur;

    if (t1m_p1) begin
      cw_n  = CW_W'(neg_p1);
      len_n = 5'd1;
    end else begin
      // A first non-T1 level cannot be +-1 when fewer than three trailing ones exist
      if (first_cur && t1s_cur != 2'd3)
        lc = lc - 15'd2;
      first_nxt = 1'b0;

      if (sl_cur == 3'd0) begin
        if (lc < 15'd14) begin
          prefix = lc[4:0];
        end else if (lc < 15'd30) begin
          prefix  = 5'd14;
          sufsize = 4'd4;
          suffix  = 12'(lc - 15'd14);
        end else begin
          prefix  = 5'd15;
          sufsize = 4'd12;
          is_esc  = 1'b1;
          esc     = ESC_W'(lc - 15'd30);
        end
      end else begin
        thr = 15'd15 << sl_cur;
        if (lc < thr) begin
          prefix  = 5'(lc >> sl_cur);
          sufsize = {1'b0, sl_cur};
          suffix  = 12'(lc & ((15'd1 << sl_cur) - 15'd1));
        end else begin
          prefix  = 5'd15;
          sufsize = 4'd12;
          is_esc  = 1'b1;
          esc     = ESC_W'(lc - thr);
        end
      end

      if (is_esc) begin
`ifdef CAVLC_LVL_ESC_CHK_EN
        err_n  = esc > ESC_W'(4095);
        suffix = sat12(esc);
`else
        suffix = esc;
`endif
      end

      // Prefix zeros are implicit leading zeros ahead of the marker bit
      cw_n  = (CW_W'(1) << sufsize) | CW_W'(suffix);
      len_n = prefix + 5'd1 + 5'(sufsize);

      if (sl_nxt == 3'd0)
        sl_nxt = 3'd1;
      if (sl_nxt < 3'd6 && abs_p1 > (LEVEL_W'(3) << (sl_nxt - 3'd1)))
        sl_nxt = sl_nxt + 3'd1;
    end
  end

  // Stage 2: codeword register and block state
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      OutValid     <= 1'b0;
      CodeWord     <= '0;
      CodeLen      <= '0;
`ifdef CAVLC_LVL_ESC_CHK_EN
      Err          <= 1'b0;
`endif
      suffix_len   <= '0;
      first_non_t1 <= 1'b0;
      t1s_blk      <= '0;
    end else if (s2_adv) begin
      OutValid <= vld_p1;
      if (vld_p1) begin
        CodeWord     <= cw_n;
        CodeLen      <= len_n;
`ifdef CAVLC_LVL_ESC_CHK_EN
        Err          <= err_n;
`endif
        suffix_len   <= sl_nxt;
        first_non_t1 <= first_nxt;
        t1s_blk      <= t1s_cur;
      end
    end
  end

`ifndef CAVLC_LVL_ESC_CHK_EN
  assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_cavlc_level_encoder.sv
// Scoreboard bench for cavlc_level_encoder: directed cases, backpressure, reset, random blocks.
module tb_cavlc_level_encoder;

  logic               Clk = 1'b0;
  logic               nReset = 1'b0;
  logic               InValid = 1'b0;
  logic               InReady;
  logic signed [12:0] Level = 13'sd1;
  logic               TrailingOneMode = 1'b0;
  logic               BlkStart = 1'b0;
  logic [4:0]         TotalCoeff = 5'd0;
  logic [1:0]         TrailingOnes = 2'd0;
  logic               OutValid;
  logic               OutReady = 1'b0;
  logic [27:0]        CodeWord;
  logic [4:0]         CodeLen;
  logic               Err;

  cavlc_level_encoder #(.LEVEL_W(13), .CW_W(28)) dut (
    .Clk(Clk), .nReset(nReset), .InValid(InValid), .InReady(InReady),
    .Level(Level), .TrailingOneMode(TrailingOneMode), .BlkStart(BlkStart),
    .TotalCoeff(TotalCoeff), .TrailingOnes(TrailingOnes),
    .OutValid(OutValid), .OutReady(OutReady),
    .CodeWord(CodeWord), .CodeLen(CodeLen), .Err(Err)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [27:0] cw;
    logic [4:0]  len;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 0;
  int   m_sl = 0;
  int   m_t1s = 0;
  bit   m_first = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference: H.264 level code rules evaluated with integer arithmetic
  function automatic exp_t model(input int lvl, input bit t1, input bit bs, input int tc, input int t1s);
    exp_t e;
    int code, mag, prefix, sufsize, suffix, esc;
    e = '0;
    if (bs) begin
      m_sl = (tc > 10 && t1s < 3) ? 1 : 0;
      m_first = 1'b1;
      m_t1s = t1s;
    end
    if (t1) begin
      e.cw = (lvl < 0) ? 28'd1 : 28'd0;
      e.len = 5'd1;
      return e;
    end
    mag = (lvl < 0) ? -lvl : lvl;
    code = (lvl > 0) ? 2 * lvl - 2 : -2 * lvl - 1;
    if (m_first && m_t1s < 3) code -= 2;
    m_first = 1'b0;
    esc = -1;
    prefix = 0; sufsize = 0; suffix = 0;
    if (m_sl == 0) begin
      if (code < 14) begin
        prefix = code;
      end else if (code < 30) begin
        prefix = 14; sufsize = 4; suffix = code - 14;
      end else begin
        prefix = 15; sufsize = 12; esc = code - 30;
      end
    end else if (code < 15 * (1 << m_sl)) begin
      prefix = code / (1 << m_sl); sufsize = m_sl; suffix = code % (1 << m_sl);
    end else begin
      prefix = 15; sufsize = 12; esc = code - 15 * (1 << m_sl);
    end
    if (esc >= 0) begin
`ifdef CAVLC_LVL_ESC_CHK_EN
      if (esc >= 4096) begin
        e.err = 1'b1; suffix = 4095;
      end else begin
        suffix = esc;
      end
`else
      suffix = esc % 4096;
`endif
    end
    e.cw = 28'((1 << sufsize) + suffix);
    e.len = 5'(prefix + 1 + sufsize);
    if (m_sl == 0) m_sl = 1;
    if (mag > 3 * (1 << (m_sl - 1)) && m_sl < 6) m_sl++;
    return e;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge
  task automatic send(input int lvl, input bit t1, input bit bs, input int tc, input int t1s,
                      input bit use_c, input exp_t ce);
    exp_t e;
    int waitc;
    bit ok;
    Level = 13'(lvl); TrailingOneMode = t1; BlkStart = bs;
    TotalCoeff = 5'(tc); TrailingOnes = 2'(t1s); InValid = 1'b1;
    waitc = 0; ok = 1'b0;
    while (!ok && waitc < 300) begin
      @(negedge Clk);
      if (InReady) ok = 1'b1;
      else begin
        waitc++;
        @(posedge Clk); #1;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout level=%0d waited=%0d cycles", lvl, waitc);
    end else begin
      e = model(lvl, t1, bs, tc, t1s);
      if (use_c) e = ce;
      q.push_back(e);
      @(posedge Clk); #1;
    end
    InValid = 1'b0; BlkStart = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge Clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending=%0d required=0", q.size());
    end
    @(posedge Clk); #1;
  endtask

  initial begin
    forever begin
      @(posedge Clk); #1;
      case (rdy_mode)
        0: OutReady = ($urandom_range(0, 3) != 0);
        1: OutReady = 1'b0;
        default: OutReady = 1'b1;
      endcase
    end
  end

  initial begin
    exp_t e, held;
    bit stalled;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge Clk);
      if (!nReset) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_valid", 32'(OutValid), 32'd1);
          chk("stall_cw", 32'(CodeWord), 32'(held.cw));
          chk("stall_len", 32'(CodeLen), 32'(held.len));
          chk("stall_err", 32'(Err), 32'(held.err));
        end
        stalled = 1'b0;
        if (OutValid) begin
          if (!OutReady) begin
            stalled = 1'b1;
            held = {CodeWord, CodeLen, Err};
          end else if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output cw=0x%0h len=%0d with nothing pending", CodeWord, CodeLen);
          end else begin
            e = q.pop_front();
            chk("codeword", 32'(CodeWord), 32'(e.cw));
            chk("codelen", 32'(CodeLen), 32'(e.len));
            chk("err", 32'(Err), 32'(e.err));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  int items[3];
  int acc_n;

  initial begin
    exp_t e;
    int tc, t1s, mag, mn, lvl;
    bit neg;

    nReset = 1'b0;
    repeat (3) @(posedge Clk);
    #1 nReset = 1'b1;
    @(negedge Clk);
    chk("rst_outvalid", 32'(OutValid), 32'd0);
    chk("rst_codeword", 32'(CodeWord), 32'd0);
    chk("rst_codelen", 32'(CodeLen), 32'd0);
    chk("rst_err", 32'(Err), 32'd0);
    chk("rst_inready", 32'(InReady), 32'd1);
    @(posedge Clk); #1;

    send(1, 1, 1, 3, 1, 1, {28'h0, 5'd1, 1'b0});
    send(2, 0, 0, 3, 1, 1, {28'h1, 5'd1, 1'b0});
    send(3, 0, 0, 3, 1, 1, {28'h2, 5'd4, 1'b0});
    send(-8, 0, 1, 5, 3, 1, {28'h11, 5'd19, 1'b0});
    send(20, 0, 1, 4, 3, 1, {28'h1008, 5'd28, 1'b0});
    send(1, 1, 1, 11, 1, 1, {28'h0, 5'd1, 1'b0});
    send(3, 0, 0, 11, 1, 1, {28'h2, 5'd3, 1'b0});
`ifdef CAVLC_LVL_ESC_CHK_EN
    send(2100, 0, 1, 4, 3, 1, {28'h1FFF, 5'd28, 1'b1});
`else
    send(2100, 0, 1, 4, 3, 1, {28'h1048, 5'd28, 1'b0});
`endif
    drain();

    // Backpressure: three levels offered against a stalled packer
    rdy_mode = 1;
    @(posedge Clk); #1;
    items[0] = 5; items[1] = -6; items[2] = 7;
    acc_n = 0;
    for (int c = 0; c < 4; c++) begin
      if (acc_n < 3) begin
        Level = 13'(items[acc_n]); TrailingOneMode = 1'b0; BlkStart = (acc_n == 0);
        TotalCoeff = 5'd3; TrailingOnes = 2'd0; InValid = 1'b1;
      end
      @(negedge Clk);
      if (InValid && InReady) begin
        q.push_back(model(items[acc_n], 1'b0, acc_n == 0, 3, 0));
        acc_n++;
      end
      @(posedge Clk); #1;
    end
    chk("bp_accepted", 32'(acc_n), 32'd2);
    chk("bp_inready", 32'(InReady), 32'd0);
    rdy_mode = 2;
    for (int c = 0; c < 20 && acc_n < 3; c++) begin
      Level = 13'(items[acc_n]); BlkStart = 1'b0; InValid = 1'b1;
      @(negedge Clk);
      if (InReady) begin
        q.push_back(model(items[acc_n], 1'b0, 1'b0, 3, 0));
        acc_n++;
      end
      @(posedge Clk); #1;
    end
    InValid = 1'b0;
    chk("bp_third_accepted", 32'(acc_n), 32'd3);
    drain();
    rdy_mode = 0;

    // Reset while levels are in flight
    rdy_mode = 1;
    @(posedge Clk); #1;
    send(9, 0, 1, 4, 0, 0, '0);
    send(10, 0, 0, 4, 0, 0, '0);
    nReset = 1'b0;
    q.delete();
    #1;
    chk("midrst_outvalid", 32'(OutValid), 32'd0);
    chk("midrst_codeword", 32'(CodeWord), 32'd0);
    chk("midrst_codelen", 32'(CodeLen), 32'd0);
    chk("midrst_inready", 32'(InReady), 32'd1);
    @(posedge Clk); #1;
    nReset = 1'b1;
    rdy_mode = 0;

    for (int b = 0; b < 50; b++) begin
      if (b == 40) rdy_mode = 2;
      tc = $urandom_range(1, 16);
      t1s = $urandom_range(0, (tc < 3) ? tc : 3);
      for (int i = 0; i < tc; i++) begin
        if (i < t1s) begin
          lvl = ($urandom_range(0, 1) != 0) ? 1 : -1;
          send(lvl, 1'b1, i == 0, tc, t1s, 1'b0, '0);
        end else begin
          mn = (i == t1s && t1s < 3) ? 2 : 1;
          case ($urandom_range(0, 2))
            0: mag = $urandom_range(mn, 3);
            1: mag = $urandom_range(mn, 40);
            default: mag = $urandom_range(mn, 4095);
          endcase
          neg = ($urandom_range(0, 1) != 0);
          if (neg && mag > 4000 && $urandom_range(0, 3) == 0) mag = 4096;
          lvl = neg ? -mag : mag;
          send(lvl, 1'b0, i == 0, tc, t1s, 1'b0, '0);
        end
      end
    end
    drain();
    rdy_mode = 2;
    repeat (5) @(posedge Clk);
    #1;
    chk("final_queue_empty", 32'(q.size()), 32'd0);
    chk("final_outvalid", 32'(OutValid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
